// File: rtl/tanh_share_arbiter.sv
// Round-robin arbiter sharing one saturating tanh unit among NREQ requesters,
// with a registered result stage and a saturation-event counter.
module tanh_share_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [17*NREQ-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_f,
    output logic [IDW-1:0]    out_id,
    output logic              out_sat,
    output logic [15:0]       sat_cnt,
    input  logic              sat_cnt_clr
);

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_f_q, out_f_d;
    logic [IDW-1:0]    out_id_q, out_id_d;
    logic              out_sat_q, out_sat_d;
    logic [15:0]       sat_cnt_q, sat_cnt_d;
    logic [IDW-1:0]    ptr_q, ptr_d;

    logic              can_load;
    logic              found;
    logic              transfer;
    logic [IDW-1:0]    g;
    logic [NREQ-1:0]   grant_vec;
    logic [16:0]       x_sel;
    logic [15:0]       f_sat;
    logic              clamp;

    assign can_load = !out_valid_q || out_ready;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        logic [IDW:0] sum;
        found = 1'b0;
        g     = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                g     = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_vec    = '0;
        grant_vec[g] = 1'b1;
    end

    assign transfer  = rst_n && can_load && found;
    assign req_ready = transfer ? grant_vec : '0;

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == IDW'(i)) begin
                x_sel = req_x[17*i +: 17];
            end
        end
    end

    // Out of 16-bit range exactly when the sign bit and bit 15 disagree.
    always_comb begin
        f_sat = x_sel[15:0];
        clamp = 1'b0;
        if (!x_sel[16] && x_sel[15]) begin
            f_sat = 16'h7FFF;
            clamp = 1'b1;
        end else if (x_sel[16] && !x_sel[15]) begin
            f_sat = 16'h8000;
            clamp = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        ptr_d       = ptr_q;
        sat_cnt_d   = sat_cnt_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_f_d     = f_sat;
            out_id_d    = g;
            out_sat_d   = clamp;
            ptr_d       = (g == LAST_ID) ? '0 : g + IDW'(1);
        end else if (can_load) begin
            out_valid_d = 1'b0;
        end
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (transfer && clamp && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_id_q    <= '0;
            out_sat_q   <= 1'b0;
            sat_cnt_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
            sat_cnt_q   <= sat_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_tanh_share_arbiter.sv
// Directed bench for tanh_share_arbiter: reset, saturation boundaries,
// round-robin order, backpressure and the saturation counter.
module tb_tanh_share_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [17*NREQ-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_f;
    logic [1:0]        out_id;
    logic              out_sat;
    logic [15:0]       sat_cnt;
    logic              sat_cnt_clr;

    int checks = 0;
    int errors = 0;

    tanh_share_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_f       (out_f),
        .out_id      (out_id),
        .out_sat     (out_sat),
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] f, input logic [1:0] id,
                           input logic sat);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_f"}, 32'(out_f), 32'(f));
        chk({tag, "_id"}, 32'(out_id), 32'(id));
        chk({tag, "_sat"}, 32'(out_sat), 32'(sat));
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        req_x       = '0;
        out_ready   = 1'b1;
        sat_cnt_clr = 1'b0;

        // reset
        tick(); tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_f", 32'(out_f), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        chk("rst_satcnt", 32'(sat_cnt), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

        // single request from 2
        req_valid = 4'b0100;
        req_x[34 +: 17] = 17'h00123;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk_out("single", 16'h0123, 2'd2, 1'b0);
        tick();
        chk("single_drain", 32'(out_valid), 32'h0);

        // saturation boundaries from requester 0 (ptr is 3, wraps to 0)
        req_valid = 4'b0001;
        req_x[0 +: 17] = 17'h08000;
        tick();
        chk_out("sat_pos", 16'h7FFF, 2'd0, 1'b1);
        req_x[0 +: 17] = 17'h17FFF;
        tick();
        chk_out("sat_neg", 16'h8000, 2'd0, 1'b1);
        req_x[0 +: 17] = 17'h18000;
        tick();
        chk_out("edge_neg", 16'h8000, 2'd0, 1'b0);
        req_x[0 +: 17] = 17'h07FFF;
        tick();
        chk_out("edge_pos", 16'h7FFF, 2'd0, 1'b0);
        req_valid = 4'b0000;
        tick();
        chk("satcnt_two", 32'(sat_cnt), 32'd2);

        // bring ptr back to 0 via requester 3
        req_valid = 4'b1000;
        req_x[51 +: 17] = 17'h00333;
        tick();
        chk_out("to_ptr0", 16'h0333, 2'd3, 1'b0);

        // round robin, all valid
        req_x[0 +: 17]  = 17'h00010;
        req_x[17 +: 17] = 17'h00011;
        req_x[34 +: 17] = 17'h1FFF2;
        req_x[51 +: 17] = 17'h00013;
        req_valid = 4'b1111;
        tick(); chk_out("rr0", 16'h0010, 2'd0, 1'b0);
        tick(); chk_out("rr1", 16'h0011, 2'd1, 1'b0);
        tick(); chk_out("rr2", 16'hFFF2, 2'd2, 1'b0);
        tick(); chk_out("rr3", 16'h0013, 2'd3, 1'b0);
        tick(); chk_out("rr4", 16'h0010, 2'd0, 1'b0);
        tick(); chk_out("rr5", 16'h0011, 2'd1, 1'b0);
        req_valid = 4'b1101;
        tick(); chk_out("skip0", 16'hFFF2, 2'd2, 1'b0);
        tick(); chk_out("skip1", 16'h0013, 2'd3, 1'b0);
        tick(); chk_out("skip2", 16'h0010, 2'd0, 1'b0);
        tick(); chk_out("skip3", 16'hFFF2, 2'd2, 1'b0);

        // backpressure: ptr is 3, held result is id 2
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            tick();
            chk_out("stall", 16'hFFF2, 2'd2, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_out("resume", 16'h0013, 2'd3, 1'b0);

        // clear overrides a same-cycle clamping transfer
        req_valid = 4'b0001;
        req_x[0 +: 17] = 17'h08000;
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        chk_out("clr_xfer", 16'h7FFF, 2'd0, 1'b1);
        chk("clr_cnt", 32'(sat_cnt), 32'h0);

        // counter preload and saturation
        repeat (65534) tick();
        chk("cnt_fffe", 32'(sat_cnt), 32'hFFFE);
        tick();
        chk("cnt_ffff", 32'(sat_cnt), 32'hFFFF);
        tick();
        chk("cnt_hold", 32'(sat_cnt), 32'hFFFF);

        // reset during a stall discards the held result
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_cnt", 32'(sat_cnt), 32'h0);
        chk("rst_mid_f", 32'(out_f), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
